// File: rtl/accel_spi_pkg.sv
// Shared constants for the accelerometer SPI responder:
// commands, register addresses, FSM states and byte helpers.
package accel_spi_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h0A;
   localparam logic [7:0] CMD_READ  = 8'h0B;

   localparam logic [7:0] ADDR_DEVID     = 8'h00;
   localparam logic [7:0] ADDR_DEVID_MST = 8'h01;
   localparam logic [7:0] ADDR_PARTID    = 8'h02;
   localparam logic [7:0] ADDR_XL        = 8'h0E;
   localparam logic [7:0] ADDR_XH        = 8'h0F;
   localparam logic [7:0] ADDR_YL        = 8'h10;
   localparam logic [7:0] ADDR_YH        = 8'h11;
   localparam logic [7:0] ADDR_ZL        = 8'h12;
   localparam logic [7:0] ADDR_ZH        = 8'h13;
   localparam logic [7:0] ADDR_POWER_CTL = 8'h2D;

   localparam logic [7:0] DEVID_MST = 8'h1D;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_RDATA,
      ST_WDATA,
      ST_IGNORE
   } state_e;

   // High register byte: 12-bit sample sign-extended to 16 bits.
   function automatic logic [7:0] hi_byte(input logic [11:0] s);
      return {{4{s[11]}}, s[11:8]};
   endfunction

endpackage

// File: rtl/accel_spi_responder_sync.sv
// spi_sync_edge: N-stage synchronizer with rise/fall pulses.
// Ports: clk, resetn, d_i (async in), level_o, rise_o, fall_o.
module spi_sync_edge #(
   parameter int   STAGES = 2,
   parameter logic INIT   = 1'b0
) (
   input  logic clk,
   input  logic resetn,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q <= {STAGES{INIT}};
         prev_q <= INIT;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   // Pulses are combinational so that a registered consumer
   // acts STAGES+1 cycles after the pin edge.
   assign level_o = sync_q[STAGES-1];
   assign rise_o  = sync_q[STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/accel_spi_responder.sv
// SPI mode-0 slave emulating an accelerometer register map.
// Ports: clk/resetn, SCLK/CS/MOSI/MISO, sample_valid + x/y/z_in,
// power_ctl (reg 0x2D), txn_done (pulse at end of frame).
module accel_spi_responder
   import accel_spi_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] DEVID       = 8'hAD,
   parameter logic [7:0] PARTID      = 8'hF2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        SCLK,
   input  logic        CS,
   input  logic        MOSI,
   output logic        MISO,
   input  logic        sample_valid,
   input  logic [11:0] x_in,
   input  logic [11:0] y_in,
   input  logic [11:0] z_in,
   output logic [7:0]  power_ctl,
   output logic        txn_done
);

   localparam int SW = $clog2(SYNC_STAGES + 2);
   localparam logic [SW-1:0] SETTLE = SW'(SYNC_STAGES + 1);

   logic sclk_rise, sclk_fall, sclk_lvl;
   logic cs_rise, cs_fall, cs_lvl;
   logic mosi_lvl;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
      .clk(clk), .resetn(resetn), .d_i(SCLK),
      .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
      .clk(clk), .resetn(resetn), .d_i(CS),
      .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
      .clk(clk), .resetn(resetn), .d_i(MOSI),
      .level_o(mosi_lvl), .rise_o(), .fall_o()
   );

   state_e        state_q, state_d;
   logic [2:0]    bit_cnt_q;
   logic [7:0]    shift_in_q, shift_out_q;
   logic [7:0]    addr_q;
   logic          is_write_q, load_q;
   logic          miso_q, txn_done_q;
   logic [7:0]    power_ctl_q;
   logic [11:0]   x_q, y_q, z_q;
   logic [11:0]   px_q, py_q, pz_q;
   logic          pend_q;
   logic [SW-1:0] settle_q;
   logic          armed_q;

   logic       sclk_rise_v, sclk_fall_v;
   logic       in_frame, byte_done;
   logic [7:0] byte_in, rd_data;

   // SCLK edges seen while CS is high are ignored.
   assign sclk_rise_v = sclk_rise & ~cs_lvl & ~sclk_fall;
   assign sclk_fall_v = sclk_fall & ~cs_lvl & sclk_lvl == 1'b0;
   assign in_frame    = state_q != ST_IDLE;
   assign byte_in     = {shift_in_q[6:0], mosi_lvl};
   assign byte_done   = sclk_rise_v && in_frame && bit_cnt_q == 3'd7;

   assign MISO      = miso_q;
   assign power_ctl = power_ctl_q;
   assign txn_done  = txn_done_q;

   always_comb begin
      rd_data = 8'h00;
      case (addr_q)
         ADDR_DEVID:     rd_data = DEVID;
         ADDR_DEVID_MST: rd_data = DEVID_MST;
         ADDR_PARTID:    rd_data = PARTID;
         ADDR_XL:        rd_data = x_q[7:0];
         ADDR_XH:        rd_data = hi_byte(x_q);
         ADDR_YL:        rd_data = y_q[7:0];
         ADDR_YH:        rd_data = hi_byte(y_q);
         ADDR_ZL:        rd_data = z_q[7:0];
         ADDR_ZH:        rd_data = hi_byte(z_q);
         ADDR_POWER_CTL: rd_data = power_ctl_q;
         default:        rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // A CS fall only opens a frame once the CS synchronizer has
   // flushed its reset value and seen the pin high (armed_q).
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:
            if (cs_fall && armed_q) state_d = ST_CMD;
         ST_CMD:
            if (byte_done)
               state_d = (byte_in == CMD_READ || byte_in == CMD_WRITE)
                         ? ST_ADDR : ST_IGNORE;
         ST_ADDR:
            if (byte_done)
               state_d = is_write_q ? ST_WDATA : ST_RDATA;
         default: state_d = state_q;
      endcase
      if (cs_rise) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bit_cnt_q   <= '0;
         shift_in_q  <= '0;
         shift_out_q <= '0;
         addr_q      <= '0;
         is_write_q  <= 1'b0;
         load_q      <= 1'b0;
         miso_q      <= 1'b0;
         txn_done_q  <= 1'b0;
         power_ctl_q <= '0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         px_q        <= '0;
         py_q        <= '0;
         pz_q        <= '0;
         pend_q      <= 1'b0;
         settle_q    <= '0;
         armed_q     <= 1'b0;
      end else begin
         txn_done_q <= 1'b0;

         if (settle_q != SETTLE) settle_q <= settle_q + SW'(1);
         else if (cs_lvl)        armed_q  <= 1'b1;

         if (sclk_rise_v && in_frame) begin
            shift_in_q <= byte_in;
            bit_cnt_q  <= bit_cnt_q + 3'd1;
         end

         if (byte_done) begin
            case (state_q)
               ST_CMD: is_write_q <= byte_in == CMD_WRITE;
               ST_ADDR: begin
                  addr_q <= byte_in;
                  load_q <= !is_write_q;
               end
               ST_RDATA: load_q <= 1'b1;
               ST_WDATA: begin
                  if (addr_q == ADDR_POWER_CTL) power_ctl_q <= byte_in;
                  addr_q <= addr_q + 8'd1;
               end
               default: ;
            endcase
         end

         // Read bytes are fetched on the fall after a byte boundary,
         // so bit 7 is on MISO before the next rising edge.
         if (sclk_fall_v && state_q == ST_RDATA) begin
            if (load_q) begin
               miso_q      <= rd_data[7];
               shift_out_q <= {rd_data[6:0], 1'b0};
               addr_q      <= addr_q + 8'd1;
               load_q      <= 1'b0;
            end else begin
               miso_q      <= shift_out_q[7];
               shift_out_q <= {shift_out_q[6:0], 1'b0};
            end
         end

         if (cs_rise) begin
            bit_cnt_q  <= '0;
            miso_q     <= 1'b0;
            load_q     <= 1'b0;
            txn_done_q <= in_frame;
            if (pend_q) begin
               x_q <= px_q;
               y_q <= py_q;
               z_q <= pz_q;
            end
            pend_q <= 1'b0;
         end

         // Strobes inside a frame are parked so a burst never tears.
         if (sample_valid) begin
            if (cs_lvl) begin
               x_q <= x_in;
               y_q <= y_in;
               z_q <= z_in;
            end else begin
               px_q   <= x_in;
               py_q   <= y_in;
               pz_q   <= z_in;
               pend_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_accel_spi_responder.sv
// Self-checking bench for accel_spi_responder: directed plan plus
// randomized frames against a register-map reference model.
module tb_accel_spi_responder;

   localparam int N    = 2;
   localparam int HALF = 6;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        SCLK = 1'b0;
   logic        CS = 1'b1;
   logic        MOSI = 1'b0;
   logic        MISO;
   logic        sample_valid = 1'b0;
   logic [11:0] x_in = '0, y_in = '0, z_in = '0;
   logic [7:0]  power_ctl;
   logic        txn_done;

   accel_spi_responder #(.SYNC_STAGES(N)) dut (
      .clk(clk), .resetn(resetn),
      .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
      .sample_valid(sample_valid),
      .x_in(x_in), .y_in(y_in), .z_in(z_in),
      .power_ctl(power_ctl), .txn_done(txn_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int txn_cnt = 0;
   int miso_ones = 0;
   bit mon_en = 0;

   always @(negedge clk) begin
      if (txn_done === 1'b1) txn_cnt++;
      if (mon_en && MISO !== 1'b0) miso_ones++;
   end

   // Reference model: committed samples, pending samples, POWER_CTL.
   logic [11:0] mx = '0, my = '0, mz = '0;
   logic [11:0] px = '0, py = '0, pz = '0;
   bit          pend = 0;
   logic [7:0]  mpwr = '0;
   bit          cs_low = 0;

   function automatic logic [7:0] ref_rd(input logic [7:0] a);
      logic [15:0] sx, sy, sz;
      sx = 16'($signed(mx));
      sy = 16'($signed(my));
      sz = 16'($signed(mz));
      case (a)
         8'h00: return 8'hAD;
         8'h01: return 8'h1D;
         8'h02: return 8'hF2;
         8'h0E: return sx[7:0];
         8'h0F: return sx[15:8];
         8'h10: return sy[7:0];
         8'h11: return sy[15:8];
         8'h12: return sz[7:0];
         8'h13: return sz[15:8];
         8'h2D: return mpwr;
         default: return 8'h00;
      endcase
   endfunction

   task automatic check8(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checki(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic xfer_bits(input logic [7:0] tx, input int n,
                            output logic [7:0] rx);
      rx = '0;
      for (int i = 0; i < n; i++) begin
         MOSI = tx[7-i];
         wait_clk(HALF);
         rx = {rx[6:0], MISO};
         SCLK = 1'b1;
         wait_clk(HALF);
         SCLK = 1'b0;
      end
   endtask

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
      xfer_bits(tx, 8, rx);
   endtask

   task automatic cs_lo();
      CS = 1'b0;
      cs_low = 1;
      wait_clk(HALF);
   endtask

   task automatic cs_hi();
      wait_clk(HALF);
      CS = 1'b1;
      cs_low = 0;
      wait_clk(N + 4);
      if (pend) begin
         mx = px; my = py; mz = pz;
         pend = 0;
      end
   endtask

   task automatic strobe(input logic [11:0] x, input logic [11:0] y,
                         input logic [11:0] z);
      @(negedge clk);
      x_in = x; y_in = y; z_in = z;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      if (cs_low) begin
         px = x; py = y; pz = z;
         pend = 1;
      end else begin
         mx = x; my = y; mz = z;
      end
   endtask

   task automatic read_burst(input logic [7:0] a, input int n,
                             input bit mid, input logic [11:0] sx,
                             input logic [11:0] sy, input logic [11:0] sz);
      logic [7:0] rx, exp;
      int t0;
      t0 = txn_cnt;
      cs_lo();
      xfer(8'h0B, rx);
      xfer(a, rx);
      for (int i = 0; i < n; i++) begin
         exp = ref_rd(a + 8'(i));
         xfer(8'h00, rx);
         check8($sformatf("rd[%02h+%0d]", a, i), rx, exp);
         if (mid && i == 0) strobe(sx, sy, sz);
      end
      cs_hi();
      checki("rd_txn_done", txn_cnt - t0, 1);
      check8("miso_idle", {7'd0, MISO}, 8'h00);
   endtask

   task automatic write_burst(input logic [7:0] a, input int n);
      logic [7:0] rx, v;
      int t0;
      t0 = txn_cnt;
      cs_lo();
      xfer(8'h0A, rx);
      xfer(a, rx);
      for (int i = 0; i < n; i++) begin
         v = 8'($urandom);
         xfer(v, rx);
         if (a + 8'(i) == 8'h2D) mpwr = v;
      end
      cs_hi();
      check8("wr_power_ctl", power_ctl, mpwr);
      checki("wr_txn_done", txn_cnt - t0, 1);
   endtask

   initial begin
      logic [7:0] rx, a;
      int t0;

      wait_clk(4);
      check8("rst_miso", {7'd0, MISO}, 8'h00);
      check8("rst_power_ctl", power_ctl, 8'h00);
      check8("rst_txn_done", {7'd0, txn_done}, 8'h00);
      resetn = 1'b1;
      wait_clk(10);

      read_burst(8'h00, 3, 0, '0, '0, '0);

      strobe(12'h345, 12'hFA5, 12'h800);
      read_burst(8'h10, 2, 0, '0, '0, '0);
      check8("y_lo_direct", ref_rd(8'h10), 8'hA5);

      read_burst(8'h12, 2, 1, 12'h345, 12'hFA5, 12'h123);
      read_burst(8'h12, 2, 0, '0, '0, '0);
      check8("z_after_commit", ref_rd(8'h13), 8'h01);

      cs_lo();
      xfer(8'h0A, rx);
      xfer(8'h2D, rx);
      xfer(8'h02, rx);
      mpwr = 8'h02;
      cs_hi();
      check8("pwr_write", power_ctl, 8'h02);
      read_burst(8'h2D, 1, 0, '0, '0, '0);

      t0 = txn_cnt;
      cs_lo();
      xfer(8'h0A, rx);
      xfer(8'h2D, rx);
      xfer_bits(8'hFF, 5, rx);
      cs_hi();
      check8("pwr_abort", power_ctl, 8'h02);
      checki("abort_txn_done", txn_cnt - t0, 1);

      t0 = txn_cnt;
      miso_ones = 0;
      cs_lo();
      mon_en = 1;
      xfer(8'h55, rx);
      xfer(8'hFF, rx);
      xfer(8'h0B, rx);
      mon_en = 0;
      cs_hi();
      checki("ignore_miso", miso_ones, 0);
      checki("ignore_txn_done", txn_cnt - t0, 1);
      read_burst(8'h01, 2, 0, '0, '0, '0);

      read_burst(8'hFF, 2, 0, '0, '0, '0);

      for (int it = 0; it < 20; it++) begin
         case ($urandom_range(0, 3))
            0: strobe(12'($urandom), 12'($urandom), 12'($urandom));
            1, 3: begin
               case ($urandom_range(0, 5))
                  0: a = 8'h00;
                  1: a = 8'h0E;
                  2: a = 8'h10;
                  3: a = 8'h12;
                  4: a = 8'h2C;
                  default: a = 8'($urandom);
               endcase
               read_burst(a, $urandom_range(0, 4), $urandom_range(0, 1) == 1,
                          12'($urandom), 12'($urandom), 12'($urandom));
            end
            default: write_burst(8'h2B + 8'($urandom_range(0, 3)),
                                 $urandom_range(1, 3));
         endcase
      end

      cs_lo();
      xfer(8'h0B, rx);
      xfer_bits(8'h02, 3, rx);
      resetn = 1'b0;
      mx = '0; my = '0; mz = '0; pend = 0; mpwr = '0;
      wait_clk(2);
      check8("midrst_miso", {7'd0, MISO}, 8'h00);
      check8("midrst_power_ctl", power_ctl, 8'h00);
      check8("midrst_txn_done", {7'd0, txn_done}, 8'h00);
      wait_clk(3);
      resetn = 1'b1;
      wait_clk(10);
      CS = 1'b1;
      cs_low = 0;
      wait_clk(N + 6);
      read_burst(8'h02, 1, 0, '0, '0, '0);
      read_burst(8'h0E, 2, 0, '0, '0, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
